// File: rtl/pipe_seq_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states, op kinds and error bit positions.
package pipe_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    StBegin    = 3'b000,
    StNormal   = 3'b001,
    StStallFpu = 3'b010,
    StStallIn  = 3'b011,
    StStallOut = 3'b100
  } state_e;

  typedef enum logic [1:0] {
    KindPlain = 2'b00,
    KindFpu   = 2'b01,
    KindIoIn  = 2'b10,
    KindIoOut = 2'b11
  } kind_e;

  localparam int unsigned ErrLost  = 7;
  localparam int unsigned ErrCarry = 6;
  localparam int unsigned ErrIo    = 5;

endpackage

// File: rtl/pipe_seq_ctrl_sync_fifo.sv
// Synchronous FIFO with binary pointers; full/empty come from an occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == (PtrW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW+1)'(1);
        2'b01:   count_q <= count_q - (PtrW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy is what defines valid data.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Pipeline stall sequencer beside EX1: holds the pipe for multi-cycle FPU ops and buffered IO.
module pipe_seq_ctrl
  import pipe_seq_ctrl_pkg::*;
#(
  parameter int unsigned IO_W      = 8,
  parameter int unsigned IN_DEPTH  = 4,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned LAT_W     = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_vld,
  input  logic [1:0]       req_kind,
  input  logic [LAT_W-1:0] req_lat,
  input  logic [IO_W-1:0]  req_wdata,
  output logic             stall,
  output logic             done,
  output logic [IO_W-1:0]  rdata,
  input  logic [IO_W-1:0]  io_in_data,
  input  logic             io_in_vld,
  output logic             io_in_rdy,
  output logic [IO_W-1:0]  io_out_data,
  output logic             io_out_vld,
  input  logic             io_out_rdy,
  input  logic [4:0]       io_err,
  output logic [7:0]       err,
  output logic [2:0]       state
);

  state_e           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [IO_W-1:0]  wdata_q, tx_wdata;
  logic [7:0]       err_q, err_d;
  logic             lost;
  logic             rx_full, rx_empty, rx_pop;
  logic             tx_full, tx_empty, tx_push;

  sync_fifo #(.WIDTH(IO_W), .DEPTH(IN_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (io_in_vld),
    .wdata (io_in_data),
    .pop   (rx_pop),
    .rdata (rdata),
    .full  (rx_full),
    .empty (rx_empty)
  );

  sync_fifo #(.WIDTH(IO_W), .DEPTH(OUT_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (tx_push),
    .wdata (tx_wdata),
    .pop   (io_out_rdy),
    .rdata (io_out_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign io_in_rdy  = ~rx_full;
  assign io_out_vld = ~tx_empty;
  assign err        = err_q;
  assign state      = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    done     = 1'b0;
    rx_pop   = 1'b0;
    tx_push  = 1'b0;
    tx_wdata = wdata_q;
    lost     = 1'b0;
    case (state_q)
      StBegin: begin
        stall   = 1'b1;
        state_d = StNormal;
      end
      StNormal: begin
        if (req_vld) begin
          unique case (kind_e'(req_kind))
            KindPlain: ;
            KindFpu: begin
              if (req_lat == '0) begin
                done = 1'b1;
              end else begin
                stall   = 1'b1;
                cnt_d   = req_lat - LAT_W'(1);
                state_d = StStallFpu;
              end
            end
            KindIoIn: begin
              if (!rx_empty) begin
                done   = 1'b1;
                rx_pop = 1'b1;
              end else begin
                stall   = 1'b1;
                state_d = StStallIn;
              end
            end
            KindIoOut: begin
              tx_wdata = req_wdata;
              if (!tx_full) begin
                done    = 1'b1;
                tx_push = 1'b1;
              end else begin
                stall   = 1'b1;
                state_d = StStallOut;
              end
            end
          endcase
        end
      end
      StStallFpu: begin
        if (cnt_q != '0) begin
          stall = 1'b1;
          cnt_d = cnt_q - LAT_W'(1);
        end else begin
          done    = 1'b1;
          state_d = StNormal;
        end
      end
      StStallIn: begin
        if (!rx_empty) begin
          done    = 1'b1;
          rx_pop  = 1'b1;
          state_d = StNormal;
        end else begin
          stall = 1'b1;
        end
      end
      StStallOut: begin
        if (!tx_full) begin
          done    = 1'b1;
          tx_push = 1'b1;
          state_d = StNormal;
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        // Corrupted state: flag it and recover without completing anything.
        lost    = 1'b1;
        stall   = 1'b1;
        state_d = StNormal;
      end
    endcase
  end

  always_comb begin
    err_d           = err_q;
    err_d[4:0]      = err_q[4:0] | io_err;
    err_d[ErrIo]    = err_q[ErrIo] | (|io_err);
    err_d[ErrCarry] = 1'b0;
    err_d[ErrLost]  = err_q[ErrLost] | lost;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StBegin;
      cnt_q   <= '0;
      wdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      // Capture the IO-out byte at acceptance so a stalled push uses it.
      if (state_q == StNormal) wdata_q <= req_wdata;
    end
  end

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Directed bench for pipe_seq_ctrl: reset, FPU latency, buffered IO in/out, errors, mid-op reset.
module tb_pipe_seq_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       req_vld;
  logic [1:0] req_kind;
  logic [3:0] req_lat;
  logic [7:0] req_wdata;
  logic       stall, done;
  logic [7:0] rdata;
  logic [7:0] io_in_data;
  logic       io_in_vld, io_in_rdy;
  logic [7:0] io_out_data;
  logic       io_out_vld, io_out_rdy;
  logic [4:0] io_err;
  logic [7:0] err;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_seq_ctrl #(.IO_W(8), .IN_DEPTH(4), .OUT_DEPTH(4), .LAT_W(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_vld     (req_vld),
    .req_kind    (req_kind),
    .req_lat     (req_lat),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .done        (done),
    .rdata       (rdata),
    .io_in_data  (io_in_data),
    .io_in_vld   (io_in_vld),
    .io_in_rdy   (io_in_rdy),
    .io_out_data (io_out_data),
    .io_out_vld  (io_out_vld),
    .io_out_rdy  (io_out_rdy),
    .io_err      (io_err),
    .err         (err),
    .state       (state)
  );

  // Request fields must not move while the pipe is held on an accepted op.
  logic        prev_hold = 1'b0;
  logic [13:0] prev_bits = '0;
  always @(negedge clk) begin
    if (prev_hold && rstn)
      assert ({req_kind, req_lat, req_wdata} === prev_bits)
      else $error("FAIL protocol req changed during stall");
    prev_hold <= rstn && req_vld && stall && (state != 3'd0);
    prev_bits <= {req_kind, req_lat, req_wdata};
  end

  // Drive point: 2 time units after the rising edge; checks follow 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_vld = 0; req_kind = 0; req_lat = 0; req_wdata = 0;
    io_in_data = 0; io_in_vld = 0; io_out_rdy = 0; io_err = 0;
    repeat (2) cyc();
    rstn = 1'b1;
    #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall got %0b want 1", stall); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (io_in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got %0b want 1", io_in_rdy); end
    checks++; if (io_out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got %0b want 0", io_out_vld); end
    checks++; if (err !== 8'h00) begin errors++; $display("FAIL reset_err got %h want 00", err); end
    cyc(); #1;
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL begin_to_normal got %0d want 1", state); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL normal_idle_stall got %0b want 0", stall); end
  endtask

  task automatic test_fpu();
    cyc();
    req_vld = 1; req_kind = 2'b01; req_lat = 4'd3;
    #1;
    checks++; if (stall !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL fpu3_t0 got stall=%0b done=%0b want 1/0", stall, done); end
    for (int k = 1; k <= 2; k++) begin
      cyc(); #1;
      checks++; if (stall !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL fpu3_t%0d got stall=%0b done=%0b want 1/0", k, stall, done); end
    end
    cyc(); #1;
    checks++; if (done !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL fpu3_t3 got done=%0b stall=%0b want 1/0", done, stall); end
    req_vld = 0;
    cyc();
    req_vld = 1; req_kind = 2'b01; req_lat = 4'd0;
    #1;
    checks++; if (done !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL fpu0 got done=%0b stall=%0b want 1/0", done, stall); end
    cyc();
    req_vld = 0;
    #1;
    checks++; if (state !== 3'd1 || done !== 1'b0) begin errors++; $display("FAIL fpu0_after got state=%0d done=%0b want 1/0", state, done); end
  endtask

  task automatic test_io_in();
    cyc();
    req_vld = 1; req_kind = 2'b10;
    #1;
    checks++; if (stall !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL in_wait_t0 got stall=%0b done=%0b want 1/0", stall, done); end
    for (int k = 1; k <= 4; k++) begin
      cyc(); #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL in_wait_t%0d got stall=%0b want 1", k, stall); end
    end
    cyc();
    io_in_vld = 1; io_in_data = 8'hA5;
    #1;
    checks++; if (stall !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL in_wait_t5 got stall=%0b done=%0b want 1/0", stall, done); end
    cyc();
    io_in_vld = 0;
    #1;
    checks++; if (done !== 1'b1 || stall !== 1'b0 || rdata !== 8'hA5) begin
      errors++; $display("FAIL in_t6 got done=%0b stall=%0b rdata=%h want 1/0/a5", done, stall, rdata);
    end
    req_vld = 0;
    cyc();
    io_in_vld = 1; io_in_data = 8'h3C;
    cyc();
    io_in_vld = 0; req_vld = 1; req_kind = 2'b10;
    #1;
    checks++; if (done !== 1'b1 || stall !== 1'b0 || rdata !== 8'h3C) begin
      errors++; $display("FAIL in_fast got done=%0b stall=%0b rdata=%h want 1/0/3c", done, stall, rdata);
    end
    cyc();
    req_vld = 0;
  endtask

  task automatic test_rx_fill();
    for (int i = 0; i < 4; i++) begin
      cyc();
      io_in_vld = 1; io_in_data = 8'h10 + 8'(i);
    end
    cyc();
    io_in_data = 8'hEE; req_vld = 1; req_kind = 2'b10;
    #1;
    checks++; if (io_in_rdy !== 1'b0) begin errors++; $display("FAIL rx_full_rdy got %0b want 0", io_in_rdy); end
    checks++; if (done !== 1'b1 || rdata !== 8'h10) begin errors++; $display("FAIL rx_pop0 got done=%0b rdata=%h want 1/10", done, rdata); end
    cyc();
    io_in_vld = 0; req_vld = 0;
    #1;
    checks++; if (io_in_rdy !== 1'b1) begin errors++; $display("FAIL rx_rdy_after_pop got %0b want 1", io_in_rdy); end
    for (int j = 1; j <= 3; j++) begin
      cyc();
      req_vld = 1; req_kind = 2'b10;
      #1;
      checks++; if (done !== 1'b1 || rdata !== 8'h10 + 8'(j)) begin
        errors++; $display("FAIL rx_order%0d got done=%0b rdata=%h want 1/%h", j, done, rdata, 8'h10 + 8'(j));
      end
    end
    cyc(); #1;
    checks++; if (stall !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rx_refused_full got stall=%0b done=%0b want 1/0", stall, done); end
    io_in_vld = 1; io_in_data = 8'h77;
    cyc();
    io_in_vld = 0;
    #1;
    checks++; if (done !== 1'b1 || rdata !== 8'h77) begin errors++; $display("FAIL rx_late got done=%0b rdata=%h want 1/77", done, rdata); end
    req_vld = 0;
  endtask

  task automatic test_tx();
    io_out_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      req_vld = 1; req_kind = 2'b11; req_wdata = 8'hB0 + 8'(i);
      #1;
      checks++; if (done !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL tx_push%0d got done=%0b stall=%0b want 1/0", i, done, stall); end
    end
    cyc();
    req_wdata = 8'hB4;
    #1;
    checks++; if (stall !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL tx_full_stall got stall=%0b done=%0b want 1/0", stall, done); end
    checks++; if (io_out_vld !== 1'b1 || io_out_data !== 8'hB0) begin
      errors++; $display("FAIL tx_head0 got vld=%0b data=%h want 1/b0", io_out_vld, io_out_data);
    end
    cyc(); #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL tx_still_stall got %0b want 1", stall); end
    io_out_rdy = 1;
    cyc(); #1;
    checks++; if (done !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL tx_fifth_done got done=%0b stall=%0b want 1/0", done, stall); end
    checks++; if (io_out_data !== 8'hB1) begin errors++; $display("FAIL tx_head1 got %h want b1", io_out_data); end
    req_vld = 0;
    for (int k = 2; k <= 4; k++) begin
      cyc(); #1;
      checks++; if (io_out_vld !== 1'b1 || io_out_data !== 8'hB0 + 8'(k)) begin
        errors++; $display("FAIL tx_head%0d got vld=%0b data=%h want 1/%h", k, io_out_vld, io_out_data, 8'hB0 + 8'(k));
      end
    end
    cyc(); #1;
    checks++; if (io_out_vld !== 1'b0) begin errors++; $display("FAIL tx_drained got %0b want 0", io_out_vld); end
    io_out_rdy = 0;
  endtask

  task automatic test_err_reset();
    cyc();
    io_err = 5'b00100;
    #1;
    checks++; if (err !== 8'h00) begin errors++; $display("FAIL err_before got %h want 00", err); end
    cyc();
    io_err = 5'b00000;
    #1;
    checks++; if (err !== 8'h24) begin errors++; $display("FAIL err_set got %h want 24", err); end
    cyc(); #1;
    checks++; if (err !== 8'h24) begin errors++; $display("FAIL err_held got %h want 24", err); end
    req_vld = 1; req_kind = 2'b01; req_lat = 4'd5;
    cyc(); #1;
    checks++; if (state !== 3'd2 || stall !== 1'b1) begin errors++; $display("FAIL fpu5_stall got state=%0d stall=%0b want 2/1", state, stall); end
    cyc();
    rstn = 0;
    #1;
    checks++; if (state !== 3'd0 || done !== 1'b0) begin errors++; $display("FAIL midop_reset got state=%0d done=%0b want 0/0", state, done); end
    checks++; if (err !== 8'h00) begin errors++; $display("FAIL midop_err got %h want 00", err); end
    req_vld = 0;
    cyc();
    rstn = 1;
    #1;
    checks++; if (state !== 3'd0 || stall !== 1'b1) begin errors++; $display("FAIL midop_begin got state=%0d stall=%0b want 0/1", state, stall); end
    for (int k = 0; k < 6; k++) begin
      cyc(); #1;
      checks++; if (done !== 1'b0 || state !== 3'd1) begin
        errors++; $display("FAIL midop_quiet%0d got done=%0b state=%0d want 0/1", k, done, state);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fpu();
    test_io_in();
    test_rx_fill();
    test_tx();
    test_err_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
